// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        imem_rd_o,
    output logic [15:0] imem_addr_o,
    input  logic [15:0] imem_data_i,
    input  logic        imem_done_i,
    output logic [15:0] instr_o,
    output logic [15:0] pc_plus2_o,
    output logic        valid_o,
    output logic        align_err_o
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_HOLD  = 3'd1,
        S_DRAIN = 3'd2,
        S_HALT  = 3'd3
    } state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] buf_instr, buf_instr_n;
    logic [15:0] buf_pc2, buf_pc2_n;
    logic [15:0] instr_n, pc_plus2_n;
    logic        valid_n, err_n;
    logic [15:0] pc_inc;
    logic        req_active;

    assign pc_inc     = pc + 16'd2;
    // A request is live while fetching an aligned pc, or while waiting out a stale one.
    assign req_active = ((state == S_FETCH) && !pc[0]) || (state == S_DRAIN);
    assign imem_rd_o  = rst && req_active;
    assign imem_addr_o = pc;

    // Next-state, pc, buffer and IF/ID selection.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        buf_instr_n = buf_instr;
        buf_pc2_n   = buf_pc2;
        instr_n     = instr_o;
        pc_plus2_n  = pc_plus2_o;
        valid_n     = valid_o;
        err_n       = align_err_o;

        if ((state != S_HALT) && redirect_i) begin
            // Flush: any response arriving now belongs to the old path.
            pc_n        = redirect_pc_i;
            instr_n     = NOP_INSTR;
            pc_plus2_n  = 16'h0000;
            valid_n     = 1'b0;
            err_n       = 1'b0;
            buf_instr_n = 16'h0000;
            buf_pc2_n   = 16'h0000;
            state_n     = (req_active && !imem_done_i) ? S_DRAIN : S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (halt_i) begin
                        state_n = S_HALT;
                        if (!stall_i) begin
                            instr_n    = NOP_INSTR;
                            pc_plus2_n = 16'h0000;
                            valid_n    = 1'b0;
                            err_n      = 1'b0;
                        end
                    end else if (pc[0]) begin
                        // Misaligned pc: hand decode a fault slot, then stop.
                        if (!stall_i) begin
                            instr_n    = NOP_INSTR;
                            pc_plus2_n = pc_inc;
                            valid_n    = 1'b1;
                            err_n      = 1'b1;
                            state_n    = S_HALT;
                        end
                    end else if (imem_done_i) begin
                        pc_n = pc_inc;
                        if (stall_i) begin
                            buf_instr_n = imem_data_i;
                            buf_pc2_n   = pc_inc;
                            state_n     = S_HOLD;
                        end else begin
                            instr_n    = imem_data_i;
                            pc_plus2_n = pc_inc;
                            valid_n    = 1'b1;
                            err_n      = 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (halt_i) begin
                        state_n = S_HALT;
                        if (!stall_i) begin
                            instr_n    = NOP_INSTR;
                            pc_plus2_n = 16'h0000;
                            valid_n    = 1'b0;
                            err_n      = 1'b0;
                        end
                    end else if (!stall_i) begin
                        instr_n    = buf_instr;
                        pc_plus2_n = buf_pc2;
                        valid_n    = 1'b1;
                        err_n      = 1'b0;
                        state_n    = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_done_i) begin
                        state_n = S_FETCH;
                    end
                end
                S_HALT: begin
                    state_n = S_HALT;
                end
                default: begin
                    state_n = S_FETCH;
                end
            endcase
        end
    end

    // State, pc, buffer and IF/ID registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            buf_instr   <= 16'h0000;
            buf_pc2     <= 16'h0000;
            instr_o     <= NOP_INSTR;
            pc_plus2_o  <= 16'h0000;
            valid_o     <= 1'b0;
            align_err_o <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            buf_instr   <= buf_instr_n;
            buf_pc2     <= buf_pc2_n;
            instr_o     <= instr_n;
            pc_plus2_o  <= pc_plus2_n;
            valid_o     <= valid_n;
            align_err_o <= err_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic        halt_i;
    logic        imem_rd_o;
    logic [15:0] imem_addr_o;
    logic [15:0] imem_data_i;
    logic        imem_done_i;
    logic [15:0] instr_o;
    logic [15:0] pc_plus2_o;
    logic        valid_o;
    logic        align_err_o;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat      = 1;
    int   wait_cnt = 0;

    fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .imem_rd_o     (imem_rd_o),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .imem_done_i   (imem_done_i),
        .instr_o       (instr_o),
        .pc_plus2_o    (pc_plus2_o),
        .valid_o       (valid_o),
        .align_err_o   (align_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word at addr is A000 + addr/2 + 1; a request takes lat cycles.
    always_comb begin
        imem_data_i = 16'hA000 + {1'b0, imem_addr_o[15:1]} + 16'd1;
        imem_done_i = imem_rd_o && ((wait_cnt + 1) >= lat);
    end

    initial begin
        forever begin
            @(posedge clk);
            if (!rst)
                wait_cnt <= 0;
            else if (imem_rd_o && !imem_done_i)
                wait_cnt <= wait_cnt + 1;
            else
                wait_cnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] instr, input logic [15:0] pc2, input logic err);
        exp_t e;
        e.instr = instr;
        e.pc2   = pc2;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a newly loaded valid slot shows up as a fresh pc_plus2_o or a valid rise.
    initial begin
        logic        prev_valid;
        logic [15:0] prev_pc2;
        exp_t        e;
        prev_valid = 1'b0;
        prev_pc2   = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_valid = 1'b0;
            end else begin
                if (valid_o && (!prev_valid || (pc_plus2_o != prev_pc2))) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mon_unexpected: got instr %h pc2 %h expected nothing", instr_o, pc_plus2_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mon_instr", instr_o, e.instr);
                        chk("mon_pc2", pc_plus2_o, e.pc2);
                        chk("mon_err", {15'b0, align_err_o}, {15'b0, e.err});
                    end
                end
                prev_valid = valid_o;
                prev_pc2   = pc_plus2_o;
            end
        end
    end

    initial begin
        rst = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 16'h0000;
        halt_i = 1'b0;

        // Reset state and zero-wait streaming
        lat = 1;
        repeat (2) tick();
        chk("rst_instr", instr_o, 16'h0800);
        chk("rst_valid", {15'b0, valid_o}, 16'h0000);
        chk("rst_err", {15'b0, align_err_o}, 16'h0000);
        chk("rst_pc2", pc_plus2_o, 16'h0000);
        chk("rst_rd", {15'b0, imem_rd_o}, 16'h0000);
        chk("rst_addr", imem_addr_o, 16'h0000);
        push(16'hA001, 16'h0002, 1'b0);
        push(16'hA002, 16'h0004, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        #1 rst = 1'b0;

        // Three-cycle latency from reset
        lat = 3;
        repeat (2) tick();
        push(16'hA001, 16'h0002, 1'b0);
        push(16'hA002, 16'h0004, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("lat_rd", {15'b0, imem_rd_o}, 16'h0001);
            chk("lat_addr", imem_addr_o, 16'h0000);
            chk("lat_valid", {15'b0, valid_o}, 16'h0000);
            @(posedge clk);
            #1;
        end
        chk("lat_next_addr", imem_addr_o, 16'h0002);
        chk("lat_loaded", {15'b0, valid_o}, 16'h0001);

        // Stall on the done cycle for two cycles
        tick();
        tick();
        stall_i = 1'b1;
        tick();
        chk("hold_rd", {15'b0, imem_rd_o}, 16'h0000);
        chk("hold_instr", instr_o, 16'hA001);
        chk("hold_pc2", pc_plus2_o, 16'h0002);
        tick();
        chk("hold_instr2", instr_o, 16'hA001);
        stall_i = 1'b0;
        #1 chk("hold_rd2", {15'b0, imem_rd_o}, 16'h0000);
        tick();

        // Redirect while a request at pc=4 is outstanding
        push(16'hA021, 16'h0042, 1'b0);
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0040;
        tick();
        redirect_i = 1'b0;
        chk("redir_valid", {15'b0, valid_o}, 16'h0000);
        chk("redir_instr", instr_o, 16'h0800);
        chk("drain_rd", {15'b0, imem_rd_o}, 16'h0001);
        chk("drain_addr", imem_addr_o, 16'h0040);
        tick();
        chk("drain_discard", {15'b0, valid_o}, 16'h0000);
        chk("refetch_addr", imem_addr_o, 16'h0040);
        tick();
        tick();
        tick();

        // Misaligned redirect, then frozen in HALT
        lat = 1;
        push(16'h0800, 16'h0015, 1'b1);
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0013;
        tick();
        redirect_i = 1'b0;
        chk("mis_rd", {15'b0, imem_rd_o}, 16'h0000);
        chk("mis_addr", imem_addr_o, 16'h0013);
        tick();
        chk("mis_err", {15'b0, align_err_o}, 16'h0001);
        chk("mis_valid", {15'b0, valid_o}, 16'h0001);
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0100;
        halt_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("halt_rd", {15'b0, imem_rd_o}, 16'h0000);
            chk("halt_addr", imem_addr_o, 16'h0013);
            chk("halt_pc2", pc_plus2_o, 16'h0015);
        end

        // Halt+redirect together, wrap, then halt alone
        rst = 1'b0;
        repeat (2) tick();
        push(16'hA041, 16'h0082, 1'b0);
        push(16'h2000, 16'h0000, 1'b0);
        push(16'hA001, 16'h0002, 1'b0);
        redirect_pc_i = 16'h0080;
        rst = 1'b1;
        tick();
        redirect_i = 1'b0;
        halt_i = 1'b0;
        chk("hr_addr", imem_addr_o, 16'h0080);
        chk("hr_rd", {15'b0, imem_rd_o}, 16'h0001);
        chk("hr_valid", {15'b0, valid_o}, 16'h0000);
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 16'hFFFE;
        tick();
        redirect_i = 1'b0;
        chk("wrap_addr0", imem_addr_o, 16'hFFFE);
        chk("wrap_valid0", {15'b0, valid_o}, 16'h0000);
        tick();
        chk("wrap_addr1", imem_addr_o, 16'h0000);
        tick();
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        chk("hlt_rd", {15'b0, imem_rd_o}, 16'h0000);
        chk("hlt_valid", {15'b0, valid_o}, 16'h0000);
        chk("hlt_instr", instr_o, 16'h0800);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hlt_rd_stay", {15'b0, imem_rd_o}, 16'h0000);
            chk("hlt_addr_stay", imem_addr_o, 16'h0002);
        end

        // Reset pulse restarts fetch at RESET_PC
        rst = 1'b0;
        repeat (2) tick();
        push(16'hA001, 16'h0002, 1'b0);
        rst = 1'b1;
        #2;
        chk("restart_rd", {15'b0, imem_rd_o}, 16'h0001);
        chk("restart_addr", imem_addr_o, 16'h0000);
        tick();
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("queue_empty", exp_q.size()[15:0], 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage plus IF/ID pipeline register, directly upstream of decode. It holds the PC and issues requests to a variable-latency instruction memory. It presents instr_o/valid_o/align_err_o/pc_plus2_o to decode. It absorbs decode hazard stalls, redirects on branch/jump resolution, and stops fetching after a halt or a misaligned fetch.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, instruction word driven when the IF/ID slot is empty or flushed

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
stall_i  in  1  hazard stall from decode; IF/ID must hold
redirect_i  in  1  branch/jump taken or mispredict; flush and refetch
redirect_pc_i  in  16  target PC, valid when redirect_i=1
halt_i  in  1  decode holds a valid HALT; stop fetching
imem_rd_o  out  1  instruction memory read request
imem_addr_o  out  16  instruction memory address (= pc)
imem_data_i  in  16  read data, valid when imem_done_i=1
imem_done_i  in  1  read complete this cycle (may be the same cycle as the request)
instr_o  out  16  IF/ID instruction
pc_plus2_o  out  16  IF/ID fetched PC + 2 (mod 2^16)
valid_o  out  1  IF/ID slot holds a real instruction
align_err_o  out  1  IF/ID slot is a misaligned-fetch fault

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, state=FETCH, instr_o=NOP_INSTR, valid_o=0, align_err_o=0, pc_plus2_o=0, buffer cleared. imem_rd_o is combinational and is 0 while rst=0.
- States: FETCH, HOLD, DRAIN, HALT (3-bit encoding).
- imem_rd_o=1 only in FETCH with pc[0]=0, and in DRAIN. imem_addr_o=pc always. Address must stay stable while rd is held and done=0.
- "IF/ID load X" means instr_o, pc_plus2_o, valid_o and align_err_o all take the values of X on the clock edge.
- FETCH, pc[0]=0, done=1, stall_i=0: IF/ID load {imem_data_i, pc+2, valid=1, err=0}; pc<=pc+2; stay in FETCH. Zero-wait memory yields 1 instruction/cycle.
- FETCH, done=1, stall_i=1: buffer <= {imem_data_i, pc+2}; pc<=pc+2; go to HOLD. IF/ID is unchanged.
- FETCH, done=0: hold rd/addr, no state change. stall_i has no effect on IF/ID except holding it.
- HOLD: imem_rd_o=0. When stall_i=0: IF/ID load buffer (valid=1); go to FETCH.
- FETCH, pc[0]=1: no request. When stall_i=0: IF/ID load {NOP_INSTR, pc+2, valid=1, err=1}; go to HALT. Decode converts this to a HALT.
- Redirect (priority over stall_i, halt_i, done; below reset), in any state except HALT:
  - pc<=redirect_pc_i.
  - IF/ID load {NOP_INSTR, 0, valid=0, err=0}.
  - Buffer is dropped.
  - Next state: DRAIN if a request is outstanding (FETCH/DRAIN with done=0); otherwise FETCH. A same-cycle done response is discarded.
- DRAIN: rd held at the current pc until done; the response is discarded; then go to FETCH. A further redirect in DRAIN updates pc and stays in DRAIN until done.
- halt_i=1 with redirect_i=0, from FETCH or HOLD:
  - Go to HALT.
  - If stall_i=0, IF/ID load NOP (valid=0); the in-flight response is dropped.
  - If stall_i=1, IF/ID holds.
- halt_i in DRAIN: ignored.
- HALT: imem_rd_o=0; pc, IF/ID and buffer are frozen; redirect_i and halt_i are ignored. Exit is by reset only.
- Reset mid-request: the request is abandoned and no response is captured. A later done with no request is ignored.
- pc arithmetic is 16-bit wrap: 16'hFFFE+2=16'h0000.

Test Plan:
- Reset release, zero-wait memory returning 16'hA001, 16'hA002 for pc=0,2 -> cycle 1 after reset: instr_o=16'hA001, pc_plus2_o=2, valid_o=1; next cycle: 16'hA002, pc_plus2_o=4.
- 3-cycle memory latency -> imem_rd_o high with imem_addr_o stable for 3 cycles; IF/ID valid_o=0 until done, then instr loaded, pc 0->2.
- stall_i=1 on the done cycle for 2 cycles -> IF/ID unchanged, state HOLD, imem_rd_o=0; after stall drops, buffered instr appears with correct pc_plus2_o.
- redirect_i to 16'h0040 while a 3-cycle request at pc=4 is outstanding -> valid_o=0, instr_o=16'h0800 next cycle; old response discarded; next imem_addr_o=16'h0040, and its data reaches instr_o with pc_plus2_o=16'h0042.
- redirect_pc_i=16'h0013 -> no imem_rd_o; instr_o=16'h0800, valid_o=1, align_err_o=1, pc_plus2_o=16'h0015; then HALT with imem_rd_o=0 forever; a later redirect is ignored.
- halt_i=1 together with redirect_i=1 -> redirect wins and fetch resumes at the target; halt_i=1 alone -> imem_rd_o=0 thereafter until rst pulses low, then fetch restarts at RESET_PC.
